// File: rtl/booth_mac_array_if.sv
// Beat-in / result-out handshake bundle for booth_mac_array.
// The producer/consumer side uses master; the MAC array uses slave.
interface booth_mac_array_if #(
  parameter int LANES = 9,
  parameter int DW    = 8,
  parameter int ACCW  = 32
);
  logic                  in_valid;
  logic                  in_ready;
  logic [LANES*DW-1:0]   multiplicand;
  logic [LANES*DW-1:0]   multiplier;
  logic                  in_unsigned;
  logic                  in_last;
  logic                  out_valid;
  logic                  out_ready;
  logic [ACCW-1:0]       out_result;
  logic                  out_ovf;

  modport master (
    output in_valid, multiplicand, multiplier, in_unsigned, in_last, out_ready,
    input  in_ready, out_valid, out_result, out_ovf
  );

  modport slave (
    input  in_valid, multiplicand, multiplier, in_unsigned, in_last, out_ready,
    output in_ready, out_valid, out_result, out_ovf
  );
endinterface

// File: rtl/booth_mac_array.sv
// Pipelined radix-4 Booth multiply-accumulate array: LANES products per beat,
// reduced to one sum-of-products, accumulated per group, one result per group.
module booth_mac_array #(
  parameter int LANES = 9,
  parameter int DW    = 8,
  parameter int ACCW  = 32
) (
  input logic              clk,
  input logic              reset_n,
  booth_mac_array_if.slave bus
);

  localparam int NPP  = DW / 2 + 1;
  localparam int PPW  = DW + 2;
  localparam int SOPW = 2 * DW + 1 + $clog2(LANES);
  localparam int AW   = ((ACCW > SOPW) ? ACCW : SOPW) + 2;

  logic                en;
  logic [PPW-1:0]      pp_d  [LANES][NPP];
  logic                s1_valid, s1_last, s1_uns;
  logic [PPW-1:0]      s1_pp [LANES][NPP];
  logic [SOPW-1:0]     sop_d;
  logic                s2_valid, s2_last, s2_uns;
  logic [SOPW-1:0]     s2_sop;
  logic [AW-1:0]       sum;
  logic                add_ovf;
  logic [ACCW-1:0]     acc;
  logic                acc_ovf;
  logic [ACCW-1:0]     out_result_q;
  logic                out_ovf_q;
  logic                out_valid_q;

  assign en              = !(out_valid_q && !bus.out_ready);
  assign bus.in_ready    = en;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_result  = out_result_q;
  assign bus.out_ovf     = out_ovf_q;

  function automatic logic [PPW-1:0] ext_x(input logic [DW-1:0] v, input logic uns);
    return {{2{v[DW-1] & ~uns}}, v};
  endfunction

  function automatic logic [2:0] booth_trip(input logic [DW-1:0] v, input logic uns, input int j);
    logic [DW+2:0] yz;
    yz = {{2{v[DW-1] & ~uns}}, v, 1'b0};
    return yz[2*j+2 -: 3];
  endfunction

  function automatic logic [PPW-1:0] booth_pp(input logic [PPW-1:0] x, input logic [2:0] trip);
    case (trip)
      3'b001, 3'b010: return x;
      3'b011:         return x << 1;
      3'b100:         return -(x << 1);
      3'b101, 3'b110: return -x;
      default:        return '0;
    endcase
  endfunction

  // Top partial product only exists for unsigned operands (the zero-extended digit).
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      for (int j = 0; j < NPP; j++) begin
        pp_d[l][j] = (j == NPP - 1 && !bus.in_unsigned) ? '0 :
          booth_pp(ext_x(bus.multiplicand[LANES*DW-1-DW*l -: DW], bus.in_unsigned),
                   booth_trip(bus.multiplier[LANES*DW-1-DW*l -: DW], bus.in_unsigned, j));
      end
    end
  end

  // NOTE: combinational blocks assign a default before any conditional/loop update, so no latch is inferred.
  always_comb begin
    sop_d = '0;
    for (int l = 0; l < LANES; l++) begin
      for (int j = 0; j < NPP; j++) begin
        sop_d = sop_d + ({{(SOPW-PPW){s1_pp[l][j][PPW-1]}}, s1_pp[l][j]} << (2 * j));
      end
    end
  end

  // Each beat extends the accumulator per its own mode; overflow is judged in that mode too.
  always_comb begin
    sum     = {{(AW-ACCW){acc[ACCW-1] & ~s2_uns}}, acc}
            + {{(AW-SOPW){s2_sop[SOPW-1] & ~s2_uns}}, s2_sop};
    add_ovf = s2_uns ? (sum[AW-1:ACCW] != '0)
                     : ((sum[AW-1:ACCW-1] != '0) && (sum[AW-1:ACCW-1] != '1));
  end

  // NOTE: state registers use non-blocking assignments so every stage samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1_valid     <= 1'b0;
      s2_valid     <= 1'b0;
      acc          <= '0;
      acc_ovf      <= 1'b0;
      out_result_q <= '0;
      out_ovf_q    <= 1'b0;
      out_valid_q  <= 1'b0;
    end else if (en) begin
      s1_valid <= bus.in_valid;
      s2_valid <= s1_valid;
      if (out_valid_q) out_valid_q <= 1'b0;
      if (s2_valid) begin
        if (s2_last) begin
          out_result_q <= sum[ACCW-1:0];
          out_ovf_q    <= acc_ovf | add_ovf;
          out_valid_q  <= 1'b1;
          acc          <= '0;
          acc_ovf      <= 1'b0;
        end else begin
          acc          <= sum[ACCW-1:0];
          acc_ovf      <= acc_ovf | add_ovf;
        end
      end
    end
  end

  // NOTE: payload registers carry no reset; they are only consumed when their valid bit is set.
  always_ff @(posedge clk) begin
    if (en) begin
      s1_pp   <= pp_d;
      s1_last <= bus.in_last;
      s1_uns  <= bus.in_unsigned;
      s2_sop  <= sop_d;
      s2_last <= s1_last;
      s2_uns  <= s1_uns;
    end
  end

endmodule
